// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel strobe, free-running raster coordinates,
// and a one-pixel-latency output register stage that keeps rgb, syncs and blank aligned.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] color,
  output logic        VGA_Ready,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        frame_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        SYNC_ON  = (SYNC_POL != 0);

  typedef struct packed {
    logic [23:0] rgb;
    logic        blank;
    logic        hsync;
    logic        vsync;
  } pins_t;

  localparam pins_t PINS_RST = '{rgb: 24'h0, blank: 1'b1, hsync: ~SYNC_ON, vsync: ~SYNC_ON};

  logic [DIV_W-1:0] div_cnt;
  logic             line_end;
  logic             last_line;
  logic             active;
  logic             hs_on;
  logic             vs_on;
  pins_t            pins_d;
  pins_t            pins_q;

  // Strobe is a pure decode of the divider register; with CLK_DIV = 1 it is always high.
  always_ff @(posedge clk) begin
    if (rst)                     div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  assign VGA_Ready = (div_cnt == DIV_LAST);
  assign line_end  = (pixel_x == H_LAST);
  assign last_line = (pixel_y == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (VGA_Ready) begin
      if (line_end) begin
        pixel_x <= '0;
        pixel_y <= last_line ? 16'd0 : pixel_y + 16'd1;
      end else begin
        pixel_x <= pixel_x + 16'd1;
      end
    end
  end

  assign frame_start = VGA_Ready && line_end && last_line;

  assign active = (pixel_x < H_ACT) && (pixel_y < V_ACT);
  assign hs_on  = (pixel_x >= HS_FIRST) && (pixel_x <= HS_LAST);
  assign vs_on  = (pixel_y >= VS_FIRST) && (pixel_y <= VS_LAST);

  always_comb begin
    pins_d       = PINS_RST;
    pins_d.rgb   = active ? color : 24'h0;
    pins_d.blank = ~active;
    pins_d.hsync = hs_on ? SYNC_ON : ~SYNC_ON;
    pins_d.vsync = vs_on ? SYNC_ON : ~SYNC_ON;
  end

  // Sampling on the strobe gives every pin the same one-pixel latency.
  always_ff @(posedge clk) begin
    if (rst)            pins_q <= PINS_RST;
    else if (VGA_Ready) pins_q <= pins_d;
  end

  assign {vga_r, vga_g, vga_b} = pins_q.rgb;
  assign vga_blank = pins_q.blank;
  assign vga_hsync = pins_q.hsync;
  assign vga_vsync = pins_q.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size CLK_DIV=4 and CLK_DIV=1 instances plus a
// tiny-geometry active-high-sync instance so frame wrap and vsync fit in a short run.
module tb_vga_timing_gen;

  localparam int DIV_A[3] = '{4, 1, 2};
  localparam int HA_A[3]  = '{640, 640, 8};
  localparam int HFP_A[3] = '{16, 16, 2};
  localparam int HSY_A[3] = '{96, 96, 3};
  localparam int HBP_A[3] = '{48, 48, 2};
  localparam int VA_A[3]  = '{480, 480, 6};
  localparam int VFP_A[3] = '{10, 10, 1};
  localparam int VSY_A[3] = '{2, 2, 2};
  localparam int VBP_A[3] = '{33, 33, 1};
  localparam int POL_A[3] = '{0, 0, 1};

  typedef struct packed {
    logic [23:0] rgb;
    logic        bl;
    logic        hs;
    logic        vs;
  } pins_t;

  typedef struct {
    int          x, y;
    logic [23:0] rgb;
    logic        bl, hs, vs;
    int          nx, ny;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  int          kc = 0;
  int          nvec = 0;
  int          nfail = 0;
  int          mfail[3] = '{0, 0, 0};

  logic [23:0] col[3] = '{24'h0, 24'h0, 24'h0};
  logic        rdy[3], fs[3], hs[3], vs[3], bl[3];
  logic [15:0] px[3], py[3];
  logic [7:0]  r[3], g[3], b[3];

  always #5 clk = ~clk;

  // Clocks since the last reset edge, and whether that edge had reset asserted.
  always @(posedge clk) begin
    rst_q <= rst;
    kc    <= rst ? 0 : kc + 1;
  end

  vga_timing_gen u0 (
    .clk(clk), .rst(rst), .color(col[0]), .VGA_Ready(rdy[0]),
    .pixel_x(px[0]), .pixel_y(py[0]), .frame_start(fs[0]),
    .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
    .vga_hsync(hs[0]), .vga_vsync(vs[0]), .vga_blank(bl[0])
  );

  vga_timing_gen #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst(rst), .color(col[1]), .VGA_Ready(rdy[1]),
    .pixel_x(px[1]), .pixel_y(py[1]), .frame_start(fs[1]),
    .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
    .vga_hsync(hs[1]), .vga_vsync(vs[1]), .vga_blank(bl[1])
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1)
  ) u2 (
    .clk(clk), .rst(rst), .color(col[2]), .VGA_Ready(rdy[2]),
    .pixel_x(px[2]), .pixel_y(py[2]), .frame_start(fs[2]),
    .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]),
    .vga_hsync(hs[2]), .vga_vsync(vs[2]), .vga_blank(bl[2])
  );

  function automatic int htot(input int d);
    return HA_A[d] + HFP_A[d] + HSY_A[d] + HBP_A[d];
  endfunction

  function automatic int vtot(input int d);
    return VA_A[d] + VFP_A[d] + VSY_A[d] + VBP_A[d];
  endfunction

  function automatic logic [23:0] pat(input int x, input int y);
    return {x[7:0], y[7:0], 8'hA5};
  endfunction

  function automatic pins_t rst_pins(input int d);
    pins_t p;
    p.rgb = 24'h0;
    p.bl  = 1'b1;
    p.hs  = (POL_A[d] == 0);
    p.vs  = (POL_A[d] == 0);
    return p;
  endfunction

  // Expected pins for pixel index n counted from reset.
  function automatic pins_t exp_pins(input int d, input int n);
    pins_t p;
    int x, y;
    logic act, h, v, on;
    x   = n % htot(d);
    y   = (n / htot(d)) % vtot(d);
    act = (x < HA_A[d]) && (y < VA_A[d]);
    h   = (x >= HA_A[d] + HFP_A[d]) && (x < HA_A[d] + HFP_A[d] + HSY_A[d]);
    v   = (y >= VA_A[d] + VFP_A[d]) && (y < VA_A[d] + VFP_A[d] + VSY_A[d]);
    on  = (POL_A[d] != 0);
    p.rgb = act ? pat(x, y) : 24'h0;
    p.bl  = ~act;
    p.hs  = h ? on : ~on;
    p.vs  = v ? on : ~on;
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (kc=%0d)", nm, act, exp, kc);
    end
  endtask

  // Continuous per-instance monitoring stops after a few failures to keep the log short.
  task automatic mchk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (mfail[d] < 8) begin
      nvec++;
      if (act !== exp) begin
        nfail++;
        mfail[d]++;
        $display("FAIL u%0d_%s: got %0h, expected %0h (kc=%0d)", d, nm, act, exp, kc);
      end
    end
  endtask

  // Scoreboard: expected pins pushed when a pixel's colour is presented on a strobe,
  // popped once that strobe edge has passed.
  pins_t sbq[3][$];
  pins_t cur[3];
  logic  prdy[3] = '{1'b0, 1'b0, 1'b0};

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        int n, x, y;
        logic erdy;
        n = kc / DIV_A[d];
        x = n % htot(d);
        y = (n / htot(d)) % vtot(d);
        if (rst_q) begin
          sbq[d].delete();
          cur[d] = rst_pins(d);
        end else if (prdy[d]) begin
          if (sbq[d].size() == 0) mchk(d, "sb_empty", 1'b1, 1'b0);
          else                    cur[d] = sbq[d].pop_front();
        end
        erdy = (kc % DIV_A[d]) == DIV_A[d] - 1;
        mchk(d, "ready", rdy[d], erdy);
        mchk(d, "pixel_x", px[d], x);
        mchk(d, "pixel_y", py[d], y);
        mchk(d, "frame_start", fs[d], erdy && x == htot(d) - 1 && y == vtot(d) - 1);
        mchk(d, "pins", {r[d], g[d], b[d], bl[d], hs[d], vs[d]}, cur[d]);
        col[d] = pat(x, y);
        if (erdy) sbq[d].push_back(exp_pins(d, n));
        prdy[d] = erdy;
      end
    end
  end

  task automatic wait_kc(input int target);
    int guard = 0;
    while (kc < target && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_kc", kc, target);
  endtask

  // Wait (bounded) until a sync pin of instance d reaches lvl; returns kc at that point.
  task automatic wait_sync(input int d, input bit vert, input logic lvl, output int t);
    int guard = 0;
    @(negedge clk);
    while (((vert ? vs[d] : hs[d]) !== lvl) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) chk($sformatf("u%0d_sync_timeout", d), 1'b0, 1'b1);
    t = kc;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{x:0,   y:0,  rgb:24'h0000A5, bl:0, hs:1, vs:1, nx:1,   ny:0};
    tbl[1] = '{x:5,   y:7,  rgb:24'h0507A5, bl:0, hs:1, vs:1, nx:6,   ny:7};
    tbl[2] = '{x:639, y:7,  rgb:24'h7F07A5, bl:0, hs:1, vs:1, nx:640, ny:7};
    tbl[3] = '{x:640, y:7,  rgb:24'h000000, bl:1, hs:1, vs:1, nx:641, ny:7};
    tbl[4] = '{x:655, y:7,  rgb:24'h000000, bl:1, hs:1, vs:1, nx:656, ny:7};
    tbl[5] = '{x:656, y:7,  rgb:24'h000000, bl:1, hs:0, vs:1, nx:657, ny:7};
    tbl[6] = '{x:751, y:7,  rgb:24'h000000, bl:1, hs:0, vs:1, nx:752, ny:7};
    tbl[7] = '{x:752, y:7,  rgb:24'h000000, bl:1, hs:1, vs:1, nx:753, ny:7};
    tbl[8] = '{x:799, y:10, rgb:24'h000000, bl:1, hs:1, vs:1, nx:0,   ny:11};
    tbl[9] = '{x:0,   y:11, rgb:24'h000BA5, bl:0, hs:1, vs:1, nx:1,   ny:11};

    // Reset held for three clocks.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_u0_ready", rdy[0], 1'b0);
    chk("rst_u1_ready", rdy[1], 1'b1);
    chk("rst_u0_xy", {px[0], py[0]}, 32'h0);
    chk("rst_u0_fs", fs[0], 1'b0);
    chk("rst_u0_pins", {r[0], g[0], b[0], bl[0], hs[0], vs[0]}, {24'h0, 3'b111});
    chk("rst_u2_syncs", {hs[2], vs[2], bl[2]}, 3'b001);
    #1 rst = 1'b0;

    for (int i = 1; i <= 12; i++) begin
      wait_kc(i);
      chk($sformatf("strobe_k%0d", i), rdy[0], (i % 4) == 3);
    end

    // Reset partway through a line of u0 and mid-frame for u2.
    wait_kc(170);
    chk("pre_rst_u2_xy", {px[2], py[2]}, {16'd10, 16'd5});
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_u0_xy", {px[0], py[0]}, 32'h0);
    chk("mid_rst_u0_pins", {r[0], g[0], b[0], bl[0], hs[0], vs[0]}, {24'h0, 3'b111});
    chk("mid_rst_u2_xy", {px[2], py[2]}, 32'h0);
    chk("mid_rst_u2_pins", {r[2], g[2], b[2], bl[2], hs[2], vs[2]}, {24'h0, 3'b100});
    chk("mid_rst_u0_ready", rdy[0], 1'b0);
    #1 rst = 1'b0;

    fork
      begin : table_run
        for (int i = 0; i < 10; i++) begin
          int n;
          n = tbl[i].y * 800 + tbl[i].x;
          wait_kc((n + 1) * 4);
          chk($sformatf("tbl%0d_pins", i), {r[0], g[0], b[0], bl[0], hs[0], vs[0]},
              {tbl[i].rgb, tbl[i].bl, tbl[i].hs, tbl[i].vs});
          chk($sformatf("tbl%0d_xy", i), {px[0], py[0]}, {16'(tbl[i].nx), 16'(tbl[i].ny)});
        end
      end
      begin : u0_hsync
        int t0, t1, t2;
        wait_sync(0, 1'b0, 1'b0, t0);
        wait_sync(0, 1'b0, 1'b1, t1);
        wait_sync(0, 1'b0, 1'b0, t2);
        chk("u0_hs_first_fall", t0, 2628);
        chk("u0_hs_width", t1 - t0, 384);
        chk("u0_hs_period", t2 - t0, 3200);
      end
      begin : u2_frame
        int cnt, t0, t1, t2;
        cnt = 0;
        while (kc < 3000) begin
          @(negedge clk);
          if (fs[2]) cnt++;
        end
        chk("u2_frame_starts", cnt, 10);
        wait_sync(2, 1'b1, 1'b1, t0);
        wait_sync(2, 1'b1, 1'b0, t1);
        wait_sync(2, 1'b1, 1'b1, t2);
        chk("u2_vs_width", t1 - t0, 60);
        chk("u2_vs_period", t2 - t0, 300);
        chk("u2_vs_phase", t0 % 300, 212);
      end
      begin : u1_div1
        int t0;
        wait_kc(5);
        chk("u1_rgb_latency", {r[1], g[1], b[1]}, 24'h0400A5);
        chk("u1_x", px[1], 16'd5);
        wait_sync(1, 1'b0, 1'b0, t0);
        chk("u1_hs_fall", t0, 657);
        wait_kc(800);
        chk("u1_line_wrap", {px[1], py[1]}, {16'd0, 16'd1});
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #800000;
    nfail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the system clock. Produces the pixel strobe `VGA_Ready` and the raster coordinates `pixel_x`/`pixel_y` consumed by the graphics layers (frame/score, ball, paddles). Registers the composited 24-bit `color` returned by those layers and aligns it with hsync, vsync and blank for the DAC pins. It sits directly upstream of the frame/score drawing block and downstream of the final colour mux.

## Interface
- `CLK_DIV`, 4, system clocks per pixel (100 MHz clk -> 25 MHz pixel); legal values are >= 1.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48. Horizontal pixel counts.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33. Vertical line counts.
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low).

Ports:
- `clk` input 1 — system clock. One clock domain only.
- `rst` input 1 — synchronous reset, active-high.
- `color` input 24 — RGB888 for the current `pixel_x`/`pixel_y`, from the colour mux.
- `VGA_Ready` output 1 — pixel strobe, one clk wide, once per `CLK_DIV` clocks.
- `pixel_x` output 16 — horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800).
- `pixel_y` output 16 — vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- `frame_start` output 1 — one-clk pulse coinciding with the `VGA_Ready` that wraps the counters to (0,0).
- `vga_r`, `vga_g`, `vga_b` output 8 each — registered colour.
- `vga_hsync`, `vga_vsync` output 1 — registered syncs.
- `vga_blank` output 1 — registered blank, 1 outside the active area.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1 and wraps. `VGA_Ready` = (`div_cnt` == CLK_DIV-1), decoded from the register. When CLK_DIV = 1, `VGA_Ready` is constantly 1 after reset.
- `pixel_x` and `pixel_y` are registers. They hold for the whole pixel period and advance only on clocks where `VGA_Ready` = 1:
  - x = H_TOTAL-1 -> x = 0 and y increments; otherwise x increments.
  - y = V_TOTAL-1 with x wrap -> y = 0.
- Coordinates run through blanking. Downstream blocks rely on seeing x = 639 with `VGA_Ready`, and on seeing y - 1 before each active row.
- Live decode from the counters:
  - active = x < H_ACTIVE && y < V_ACTIVE
  - hs = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751]
  - vs = y in [490, 491]
- Output stage updates only when `VGA_Ready` = 1:
  - {r,g,b} <= active ? `color` : 0
  - `vga_blank` <= !active
  - `vga_hsync` <= hs ? SYNC_POL : !SYNC_POL
  - `vga_vsync` likewise from vs.
- `frame_start` = `VGA_Ready` && x = H_TOTAL-1 && y = V_TOTAL-1.
- Counter arithmetic is 16-bit unsigned with no other wrap path. Comparisons use parameter sums computed at elaboration.

## Timing
- Reset values (next clk edge with `rst` = 1):
  - `div_cnt` = 0, so `VGA_Ready` = 0 unless CLK_DIV = 1.
  - `pixel_x` = 0, `pixel_y` = 0, `frame_start` = 0.
  - rgb = 0, `vga_blank` = 1, syncs = !SYNC_POL (deasserted).
- `rst` mid-line or mid-frame restarts cleanly at (0,0). No partial strobe is emitted in the reset cycle.
- First `VGA_Ready` after reset release comes CLK_DIV clocks later.
- `color` is sampled on the `VGA_Ready` clock of pixel (x,y). It is valid at the pins for the following CLK_DIV clocks: a fixed one-pixel-period latency, identical for rgb, syncs and blank, so they stay mutually aligned.
- `color` must be stable by the `VGA_Ready` clock. A one-clk-latency ROM in a consumer therefore has CLK_DIV-1 clocks of slack, or must look ahead one pixel.
- Line period = 800 × CLK_DIV clocks; frame period = 525 × 800 × CLK_DIV clocks.
- Exactly one `frame_start` per frame.

## Test plan
- **Reset/strobe:** hold `rst` 3 clks, release -> all outputs at reset values; `VGA_Ready` high on clks 4, 8, 12, … (CLK_DIV = 4).
- **Line wrap:** run to x = 799, y = 10 -> the next `VGA_Ready` yields x = 0, y = 11; frame wrap at (799,524) -> (0,0), with `frame_start` high for exactly 1 clk.
- **Sync widths:** over one frame, hsync is low for 96 pixel periods starting at x = 656; vsync is low for 2 lines starting at y = 490; hsync period is 3200 clks.
- **Colour alignment:** drive `color` = {8'(x), 8'(y), 8'hA5} -> on the pins, pixel (5,7) shows 05/07/A5 during the period after its strobe; at x = 640, rgb = 0 and blank = 1.
- **Reset mid-frame:** assert `rst` at x = 300, y = 200 for 1 clk -> (0,0), rgb = 0, syncs deasserted; the next frame's sync timing is exact.
- **CLK_DIV = 1:** `VGA_Ready` is continuous; the line is 800 clks; colour latency is 1 clk.
